mem_wb_commit: RTL and testbench
================================

// Module: mem_wb_commit
// PURPOSE
//  Consumer side of the execute-stage result bundle (dst, sdata, alt_pc, br_ctrl, instr).
//  Accepts one executed instruction per valid/ready handshake and runs its data-memory access
//  (LW/SW) over a req/ack memory port. Commits the register-file write and next-PC update,
//  and stalls fetch while busy. Sits between the execute stage and the register file/PC register.
// PARAMETERS
//  OP_LW    4'b1000  opcode (instr[15:12]) of load word
//  OP_SW    4'b1001  opcode of store word
//  OP_JAL   4'b1101  opcode of jump-and-link (writes pc+1 to R15)
//  OP_HLT   4'b1111  opcode of halt
//  TIMEOUT  16       max cycles waiting for mem_ack before abort (>=1)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   execute bundle valid
//  in_ready     out  1   stage can accept bundle
//  instr        in   16  executed instruction
//  pc           in   16  address of executed instruction
//  dst          in   16  ALU result / memory address for LW,SW
//  sdata        in   16  store data for SW
//  alt_pc       in   16  branch/jump target
//  br_ctrl      in   1   1 = take alt_pc
//  mem_re       out  1   data-memory read request
//  mem_we       out  1   data-memory write request
//  mem_addr     out  16  data-memory address
//  mem_wdata    out  16  data-memory write data
//  mem_rdata    in   16  data-memory read data, valid with mem_ack
//  mem_ack      in   1   access complete
//  rf_we        out  1   register-file write strobe
//  rf_waddr     out  4   register-file write address
//  rf_wdata     out  16  register-file write data
//  pc_we        out  1   PC update strobe
//  pc_next      out  16  next PC
//  stall        out  1   hold fetch/decode (= ~in_ready & ~halted)
//  halted       out  1   sticky, HLT committed
//  mem_err      out  1   sticky, memory access timed out
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except in_ready=1; counters and latches cleared. Reset
//   mid-access drops mem_re/mem_we immediately (async); the in-flight instruction is lost.
//  FSM IDLE -> {MEM, COMMIT}; MEM -> COMMIT; COMMIT -> {IDLE, HALT}; HALT terminal until reset.
//  IDLE: in_ready=1. On in_valid&in_ready, latch all inputs. LW/SW -> MEM, else -> COMMIT.
//  MEM: in_ready=0. mem_re (LW) or mem_we (SW) held high, with mem_addr=dst and mem_wdata=sdata
//   stable until the cycle mem_ack=1 is sampled. Then capture mem_rdata and go to COMMIT.
//   The request drops in COMMIT.
//   Wait counter increments each MEM cycle without ack. At TIMEOUT cycles: set mem_err,
//   drop request, go COMMIT with load data forced to 16'h0000.
//   Ack arriving on the same cycle as timeout wins (no error).
//  mem_ack outside MEM is ignored.
//  COMMIT (exactly one cycle): pc_we=1 and rf_we/halted strobes valid.
//   pc_next = br_ctrl ? alt_pc : pc+1 (16-bit wrap, 16'hFFFF+1 = 16'h0000).
//   rf_waddr = JAL ? 4'hF : instr[11:8].
//   rf_wdata = LW ? loaded data : JAL ? pc+1 : dst.
//   rf_we = 1 for non-SW, non-branch, non-HLT, and rf_waddr != 0.
//    Branch = br_ctrl source opcode 4'b1100 / 4'b1110; writes to R0 are suppressed.
//   HLT: pc_we=0, rf_we=0, halted=1 -> HALT.
//  HALT: in_ready=0, stall=0, no strobes; only reset exits.
//  Latency: non-memory instruction accepted at cycle T commits at T+1 (ready again at T+2).
//   Memory instruction with ack k cycles after request commits k+1 cycles after acceptance.
//  rf_we and pc_we are single-cycle pulses; all outputs are registered.
// TESTING
//  ADD, dst=16'h1234, instr[11:8]=3, pc=16'h0010, br_ctrl=0
//   -> next cycle rf_we=1, waddr=3, wdata=1234, pc_next=0011; in_ready low 1 cycle.
//  LW dst=16'h0040, mem_ack 3 cycles after mem_re, rdata=16'hBEEF
//   -> mem_addr held 0040; rf_wdata=BEEF the cycle after ack; mem_err=0.
//  SW dst=16'h0050, sdata=16'hCAFE, no ack for TIMEOUT cycles
//   -> request drops at cycle TIMEOUT; mem_err=1 sticky; rf_we=0; pc_we=1.
//  JAL pc=16'hFFFF, br_ctrl=1, alt_pc=16'h0100 -> rf_waddr=F, rf_wdata=0000, pc_next=0100.
//  ADD to R0 -> rf_we=0.
//   HLT -> halted=1, in_ready stays 0 despite in_valid; async rst_n mid-LW clears mem_re at once.

Source files
------------

// File: rtl/mem_wb_commit.sv
// Memory / write-back stage: takes one executed instruction per handshake, performs its
// LW/SW over a req/ack port with a bounded wait, then commits the RF write and next PC.
module mem_wb_commit #(
  parameter logic [3:0]  OP_LW   = 4'b1000,
  parameter logic [3:0]  OP_SW   = 4'b1001,
  parameter logic [3:0]  OP_JAL  = 4'b1101,
  parameter logic [3:0]  OP_HLT  = 4'b1111,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  input  logic [15:0] pc,
  input  logic [15:0] dst,
  input  logic [15:0] sdata,
  input  logic [15:0] alt_pc,
  input  logic        br_ctrl,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        pc_we,
  output logic [15:0] pc_next,
  output logic        stall,
  output logic        halted,
  output logic        mem_err
);

  localparam int unsigned CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]  OP_BR_A  = 4'b1100;
  localparam logic [3:0]  OP_BR_B  = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_COMMIT, S_HALT} state_e;

  state_e         state_q, state_d;
  logic [3:0]     op_q, op_d, rd_q, rd_d;
  logic [15:0]    pcl_q, pcl_d, alt_q, alt_d;
  logic           br_q, br_d;
  logic [CW-1:0]  wait_q, wait_d;

  logic           in_ready_q, in_ready_d, stall_q, stall_d;
  logic           mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [15:0]    mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic           rf_we_q, rf_we_d, pc_we_q, pc_we_d;
  logic [3:0]     rf_waddr_q, rf_waddr_d;
  logic [15:0]    rf_wdata_q, rf_wdata_d, pc_next_q, pc_next_d;
  logic           halted_q, halted_d, mem_err_q, mem_err_d;

  // Low instruction bits carry no meaning for this stage.
  logic           unused_instr_bits;
  assign unused_instr_bits = ^instr[7:0];

  // Commit source: live inputs when committing straight from IDLE, latched copy after MEM.
  logic [3:0]  src_op, src_rd;
  logic [15:0] src_pc, src_alt;
  logic        src_br;

  always_comb begin
    if (state_q == S_IDLE) begin
      src_op  = instr[15:12];
      src_rd  = instr[11:8];
      src_pc  = pc;
      src_alt = alt_pc;
      src_br  = br_ctrl;
    end else begin
      src_op  = op_q;
      src_rd  = rd_q;
      src_pc  = pcl_q;
      src_alt = alt_q;
      src_br  = br_q;
    end
  end

  logic        is_lw, is_sw, is_jal, is_hlt, is_br, c_rf_we;
  logic [15:0] pc_inc, load_data, c_wdata, c_pc_next;
  logic [3:0]  c_waddr;

  assign is_lw     = (src_op == OP_LW);
  assign is_sw     = (src_op == OP_SW);
  assign is_jal    = (src_op == OP_JAL);
  assign is_hlt    = (src_op == OP_HLT);
  assign is_br     = (src_op == OP_BR_A) || (src_op == OP_BR_B);
  assign pc_inc    = src_pc + 16'd1;
  assign load_data = mem_ack ? mem_rdata : 16'h0000;
  assign c_waddr   = is_jal ? 4'hF : src_rd;
  assign c_wdata   = is_lw ? load_data : (is_jal ? pc_inc : dst);
  assign c_rf_we   = !is_sw && !is_br && !is_hlt && (c_waddr != 4'h0);
  assign c_pc_next = src_br ? src_alt : pc_inc;

  always_comb begin
    logic load_commit;
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    load_commit = 1'b0;
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    pcl_d       = pcl_q;
    alt_d       = alt_q;
    br_d        = br_q;
    wait_d      = wait_q;
    in_ready_d  = 1'b0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_we_d     = 1'b0;
    pc_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    pc_next_d   = pc_next_q;
    halted_d    = halted_q;
    mem_err_d   = mem_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d  = instr[15:12];
          rd_d  = instr[11:8];
          pcl_d = pc;
          alt_d = alt_pc;
          br_d  = br_ctrl;
          if (is_lw || is_sw) begin
            state_d     = S_MEM;
            mem_re_d    = is_lw;
            mem_we_d    = is_sw;
            mem_addr_d  = dst;
            mem_wdata_d = sdata;
            wait_d      = '0;
          end else begin
            state_d     = S_COMMIT;
            load_commit = 1'b1;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_MEM: begin
        // A late ack on the final allowed cycle still completes the access cleanly.
        if (mem_ack) begin
          state_d     = S_COMMIT;
          load_commit = 1'b1;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          state_d     = S_COMMIT;
          load_commit = 1'b1;
          mem_err_d   = 1'b1;
        end else begin
          mem_re_d = mem_re_q;
          mem_we_d = mem_we_q;
          wait_d   = wait_q + 1'b1;
        end
      end
      S_COMMIT: begin
        if (halted_q) begin
          state_d = S_HALT;
        end else begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
        end
      end
      default: state_d = S_HALT;
    endcase

    if (load_commit) begin
      rf_we_d    = c_rf_we;
      pc_we_d    = !is_hlt;
      rf_waddr_d = c_waddr;
      rf_wdata_d = c_wdata;
      pc_next_d  = c_pc_next;
      halted_d   = halted_q || is_hlt;
    end

    stall_d = !in_ready_d && !halted_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      pcl_q       <= '0;
      alt_q       <= '0;
      br_q        <= 1'b0;
      wait_q      <= '0;
      in_ready_q  <= 1'b1;
      stall_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rf_we_q     <= 1'b0;
      pc_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      pc_next_q   <= '0;
      halted_q    <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      pcl_q       <= pcl_d;
      alt_q       <= alt_d;
      br_q        <= br_d;
      wait_q      <= wait_d;
      in_ready_q  <= in_ready_d;
      stall_q     <= stall_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rf_we_q     <= rf_we_d;
      pc_we_q     <= pc_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      pc_next_q   <= pc_next_d;
      halted_q    <= halted_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign stall     = stall_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rf_we     = rf_we_q;
  assign pc_we     = pc_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pc_next   = pc_next_q;
  assign halted    = halted_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_wb_commit.sv
// Directed bench for mem_wb_commit: hand-computed expectations for ALU, LW/SW, timeout,
// JAL wrap, R0 suppression, branch, HLT and asynchronous reset mid-access.
module tb_mem_wb_commit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] instr, pc, dst, sdata, alt_pc;
  logic        br_ctrl;
  logic        mem_re, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        rf_we, pc_we, stall, halted, mem_err;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata, pc_next;

  int total = 0;
  int bad   = 0;

  mem_wb_commit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .dst(dst), .sdata(sdata), .alt_pc(alt_pc), .br_ctrl(br_ctrl),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_we(pc_we), .pc_next(pc_next),
    .stall(stall), .halted(halted), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] i, input logic [15:0] p, input logic [15:0] d,
                       input logic [15:0] s, input logic [15:0] a, input logic b);
    instr = i; pc = p; dst = d; sdata = s; alt_pc = a; br_ctrl = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; dst = '0; sdata = '0;
    alt_pc = '0; br_ctrl = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_stall",    stall,    0);
    check("rst_mem_re",   mem_re,   0);
    check("rst_mem_we",   mem_we,   0);
    check("rst_rf_we",    rf_we,    0);
    check("rst_pc_we",    pc_we,    0);
    check("rst_halted",   halted,   0);
    check("rst_mem_err",  mem_err,  0);
    check("rst_pc_next",  pc_next,  16'h0000);
    rst_n = 1'b1;
    tick();

    // ADD r3 <- 1234, commits the cycle after acceptance
    issue(16'h0300, 16'h0010, 16'h1234, 16'h0000, 16'h0000, 1'b0);
    check("add_rf_we",    rf_we,    1);
    check("add_waddr",    rf_waddr, 3);
    check("add_wdata",    rf_wdata, 16'h1234);
    check("add_pc_we",    pc_we,    1);
    check("add_pc_next",  pc_next,  16'h0011);
    check("add_ready_lo", in_ready, 0);
    check("add_stall",    stall,    1);
    tick();
    check("add_ready_hi", in_ready, 1);
    check("add_rf_we_pulse", rf_we, 0);
    check("add_pc_we_pulse", pc_we, 0);

    // Stray ack while idle has no effect
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    check("stray_ack_rf_we", rf_we, 0);
    check("stray_ack_pc_we", pc_we, 0);
    check("stray_ack_ready", in_ready, 1);

    // LW r5 <- [0040], ack three cycles after the request appears
    issue(16'h8500, 16'h0020, 16'h0040, 16'h0000, 16'h0000, 1'b0);
    check("lw_mem_re",   mem_re,   1);
    check("lw_mem_we",   mem_we,   0);
    check("lw_addr",     mem_addr, 16'h0040);
    check("lw_ready_lo", in_ready, 0);
    check("lw_stall",    stall,    1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lw_re_held",   mem_re,   1);
      check("lw_addr_held", mem_addr, 16'h0040);
    end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    check("lw_re_drop",  mem_re,   0);
    check("lw_rf_we",    rf_we,    1);
    check("lw_waddr",    rf_waddr, 5);
    check("lw_wdata",    rf_wdata, 16'hBEEF);
    check("lw_pc_next",  pc_next,  16'h0021);
    check("lw_mem_err",  mem_err,  0);
    tick();

    // LW r6 with ack on the last allowed (16th) request cycle: ack wins, no error
    issue(16'h8600, 16'h0022, 16'h0044, 16'h0000, 16'h0000, 1'b0);
    for (int i = 1; i < 16; i++) tick();
    check("lw16_re_held", mem_re, 1);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    check("lw16_wdata",   rf_wdata, 16'h5A5A);
    check("lw16_rf_we",   rf_we,    1);
    check("lw16_mem_err", mem_err,  0);
    tick();

    // SW [0050] <- CAFE, never acked: request held 16 cycles, then abort
    issue(16'h9200, 16'h0030, 16'h0050, 16'hCAFE, 16'h0000, 1'b0);
    check("sw_mem_we", mem_we,    1);
    check("sw_mem_re", mem_re,    0);
    check("sw_addr",   mem_addr,  16'h0050);
    check("sw_wdata",  mem_wdata, 16'hCAFE);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("sw_we_held", mem_we, 1);
    end
    tick();
    check("sw_to_we_drop", mem_we,  0);
    check("sw_to_err",     mem_err, 1);
    check("sw_to_rf_we",   rf_we,   0);
    check("sw_to_pc_we",   pc_we,   1);
    check("sw_to_pc_next", pc_next, 16'h0031);
    tick();
    check("sw_err_sticky", mem_err, 1);

    // LW r4 timing out: load data forced to zero even with junk on rdata
    mem_rdata = 16'h7777;
    issue(16'h8400, 16'h0033, 16'h0060, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    check("lwto_rf_we", rf_we,    1);
    check("lwto_wdata", rf_wdata, 16'h0000);
    check("lwto_re",    mem_re,   0);
    mem_rdata = 16'h0000;
    tick();

    // JAL at FFFF: link wraps to 0000 into R15, PC jumps to 0100
    issue(16'hD700, 16'hFFFF, 16'hAAAA, 16'h0000, 16'h0100, 1'b1);
    check("jal_rf_we",   rf_we,    1);
    check("jal_waddr",   rf_waddr, 16'h000F);
    check("jal_wdata",   rf_wdata, 16'h0000);
    check("jal_pc_next", pc_next,  16'h0100);
    tick();

    // ADD to R0 is suppressed but PC still advances
    issue(16'h0000, 16'h0100, 16'h1111, 16'h0000, 16'h0000, 1'b0);
    check("r0_rf_we",   rf_we,   0);
    check("r0_pc_we",   pc_we,   1);
    check("r0_pc_next", pc_next, 16'h0101);
    tick();

    // Taken branch writes no register
    issue(16'hC400, 16'h0101, 16'h2222, 16'h0000, 16'h0200, 1'b1);
    check("br_rf_we",   rf_we,   0);
    check("br_pc_we",   pc_we,   1);
    check("br_pc_next", pc_next, 16'h0200);
    tick();

    // HLT: sticky halted, no strobes, never ready again
    issue(16'hF000, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    check("hlt_halted", halted,   1);
    check("hlt_pc_we",  pc_we,    0);
    check("hlt_rf_we",  rf_we,    0);
    check("hlt_ready",  in_ready, 0);
    check("hlt_stall",  stall,    0);
    instr = 16'h0300; dst = 16'h4321; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_ready", in_ready, 0);
      check("halt_rf_we", rf_we,    0);
      check("halt_pc_we", pc_we,    0);
      check("halt_stall", stall,    0);
      check("halt_flag",  halted,   1);
    end
    in_valid = 1'b0;

    // Reset clears HALT; then async reset mid-LW drops mem_re without a clock edge
    rst_n = 1'b0;
    #1;
    check("rst_exit_halted", halted, 0);
    check("rst_exit_ready",  in_ready, 1);
    rst_n = 1'b1;
    tick();
    issue(16'h8100, 16'h0000, 16'h0070, 16'h0000, 16'h0000, 1'b0);
    check("lw2_mem_re", mem_re, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_re",  mem_re,   0);
    check("async_rst_ready",   in_ready, 1);
    check("async_rst_mem_err", mem_err,  0);
    rst_n = 1'b1;
    tick();
    check("post_rst_rf_we", rf_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
